// File: rtl/life_rule_engine.sv
// Sequential Life rule evaluator: latches a cell and its rule masks on start,
// counts serially streamed neighbour bits, then presents the next cell state.
module life_rule_engine #(
  parameter int N_NEIGHBORS = 8,
  parameter int COUNT_W = $clog2(N_NEIGHBORS + 1),
  parameter logic [N_NEIGHBORS:0] BIRTH_DEFAULT = 9'b000001000,
  parameter logic [N_NEIGHBORS:0] SURVIVE_DEFAULT = 9'b000001100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cur_state,
  input  logic                 use_custom,
  input  logic [N_NEIGHBORS:0] birth_mask,
  input  logic [N_NEIGHBORS:0] survive_mask,
  input  logic                 nb_valid,
  input  logic                 nb_bit,
  output logic                 nb_ready,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 next_state,
  output logic [COUNT_W-1:0]   count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Masks are widened to every value the count can encode so the lookup
  // index can never fall outside the vector.
  localparam int MASK_W = 1 << COUNT_W;
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(N_NEIGHBORS - 1);

  logic [1:0]           state_q, state_d;
  logic                 cur_q, cur_d;
  logic [N_NEIGHBORS:0] birth_q, birth_d;
  logic [N_NEIGHBORS:0] survive_q, survive_d;
  logic [COUNT_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0]   idx_q, idx_d;
  logic                 next_state_q, next_state_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [COUNT_W-1:0]   total;
  logic [MASK_W-1:0]    birth_ext;
  logic [MASK_W-1:0]    survive_ext;

  always_comb begin
    total       = acc_q + COUNT_W'(nb_bit);
    birth_ext   = MASK_W'(birth_q);
    survive_ext = MASK_W'(survive_q);

    state_d      = state_q;
    cur_d        = cur_q;
    birth_d      = birth_q;
    survive_d    = survive_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    next_state_d = next_state_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d     = cur_state;
          birth_d   = use_custom ? birth_mask : BIRTH_DEFAULT;
          survive_d = use_custom ? survive_mask : SURVIVE_DEFAULT;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (nb_valid) begin
          if (idx_q == LAST_IDX) begin
            next_state_d = cur_q ? survive_ext[total] : birth_ext[total];
            count_d      = total;
            state_d      = DONE;
          end else begin
            acc_d = total;
            idx_d = idx_q + COUNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_q        <= 1'b0;
      birth_q      <= '0;
      survive_q    <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      next_state_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      birth_q      <= birth_d;
      survive_q    <= survive_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      next_state_q <= next_state_d;
      count_q      <= count_d;
    end
  end

  assign nb_ready   = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign next_state = next_state_q;
  assign count      = count_q;

endmodule

// File: tb/tb_life_rule_engine.sv
// Self-checking bench for life_rule_engine: directed Test Plan scenarios plus
// randomized evaluations checked against a popcount-and-lookup rule model.
module tb_life_rule_engine;

  localparam logic [8:0] BIRTH_DEF   = 9'b000001000;
  localparam logic [8:0] SURVIVE_DEF = 9'b000001100;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cur_state;
  logic       use_custom;
  logic [8:0] birth_mask;
  logic [8:0] survive_mask;
  logic       nb_valid;
  logic       nb_bit;
  logic       nb_ready;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic       next_state;
  logic [3:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  life_rule_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cur_state    (cur_state),
    .use_custom   (use_custom),
    .birth_mask   (birth_mask),
    .survive_mask (survive_mask),
    .nb_valid     (nb_valid),
    .nb_bit       (nb_bit),
    .nb_ready     (nb_ready),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .next_state   (next_state),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule model: the outcome depends only on how many neighbours are alive.
  function automatic logic ref_next(input logic cur, input logic uc,
                                    input logic [8:0] bm, input logic [8:0] sm,
                                    input logic [7:0] bits);
    int n;
    logic [8:0] b;
    logic [8:0] s;
    n = $countones(bits);
    b = uc ? bm : BIRTH_DEF;
    s = uc ? sm : SURVIVE_DEF;
    return cur ? s[n] : b[n];
  endfunction

  // Runs one evaluation up to the first out_valid cycle; the sampled inputs
  // are scrambled right after start so any failure to latch them shows up.
  task automatic do_eval(input logic cur, input logic uc, input logic [8:0] bm,
                         input logic [8:0] sm, input logic [7:0] bits,
                         input int gap_mode, output logic ns,
                         output logic [3:0] cnt, output int lat,
                         output int last_acc, output bit timed_out);
    int b;
    int k;
    b = 0;
    lat = -1;
    last_acc = -1;
    timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cur_state = cur;
    use_custom = uc;
    birth_mask = bm;
    survive_mask = sm;
    nb_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cur_state = ~cur;
    use_custom = ~uc;
    birth_mask = '0;
    survive_mask = '0;
    k = 1;
    while (lat < 0 && k <= 60) begin
      if (out_valid) begin
        lat = k;
      end else begin
        nb_valid = 1'b0;
        if (b < 8) begin
          case (gap_mode)
            0:       nb_valid = 1'b1;
            1:       nb_valid = ((k - 1) % 3 == 0);
            default: nb_valid = 1'($urandom_range(0, 1));
          endcase
        end
        nb_bit = nb_valid ? bits[b] : 1'($urandom_range(0, 1));
        if (nb_valid && nb_ready) begin
          b++;
          last_acc = k;
        end
        @(negedge clk);
        k++;
      end
    end
    nb_valid = 1'b0;
    nb_bit = 1'b0;
    if (lat < 0) timed_out = 1'b1;
    ns = next_state;
    cnt = count;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); else n_pass++;
    n_checks++; if (nb_ready !== 1'b0) $display("[TB] FAIL reset_nb_ready: got %0b, expected 0", nb_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (next_state !== 1'b0) $display("[TB] FAIL reset_next_state: got %0b, expected 0", next_state); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("[TB] FAIL reset_count: got %0d, expected 0", count); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_rule();
    logic [7:0] bits [4] = '{8'b00000011, 8'b00010101, 8'b10000001, 8'b00001111};
    logic       curs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       ns;
    logic [3:0] cnt;
    int lat, last_acc;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_eval(curs[i], 1'b0, 9'h1FF, 9'h1FF, bits[i], 0, ns, cnt, lat, last_acc, to);
      n_checks++; if (to) $display("[TB] FAIL default_timeout: case %0d got no out_valid, expected one", i); else n_pass++;
      n_checks++; if (ns !== ref_next(curs[i], 1'b0, 9'h1FF, 9'h1FF, bits[i])) $display("[TB] FAIL default_next_state: case %0d got %0b, expected %0b", i, ns, ref_next(curs[i], 1'b0, 9'h1FF, 9'h1FF, bits[i])); else n_pass++;
      n_checks++; if (cnt !== 4'($countones(bits[i]))) $display("[TB] FAIL default_count: case %0d got %0d, expected %0d", i, cnt, $countones(bits[i])); else n_pass++;
      n_checks++; if (lat !== 9) $display("[TB] FAIL default_latency: case %0d got %0d, expected 9", i, lat); else n_pass++;
      release_result();
    end
  endtask

  task automatic test_highlife();
    logic       ns;
    logic [3:0] cnt;
    int lat, last_acc;
    bit to;
    do_eval(1'b0, 1'b1, 9'b001001000, 9'b000001100, 8'b11101101, 0, ns, cnt, lat, last_acc, to);
    n_checks++; if (to) $display("[TB] FAIL highlife_timeout: got no out_valid, expected one"); else n_pass++;
    n_checks++; if (ns !== 1'b1) $display("[TB] FAIL highlife_next_state: got %0b, expected 1", ns); else n_pass++;
    n_checks++; if (cnt !== 4'd6) $display("[TB] FAIL highlife_count: got %0d, expected 6", cnt); else n_pass++;
    release_result();
  endtask

  task automatic test_gaps();
    logic       ns;
    logic [3:0] cnt;
    int lat, last_acc;
    bit to;
    do_eval(1'b1, 1'b0, 9'h000, 9'h000, 8'hFF, 1, ns, cnt, lat, last_acc, to);
    n_checks++; if (to) $display("[TB] FAIL gaps_timeout: got no out_valid, expected one"); else n_pass++;
    n_checks++; if (ns !== 1'b0) $display("[TB] FAIL gaps_next_state: got %0b, expected 0", ns); else n_pass++;
    n_checks++; if (cnt !== 4'd8) $display("[TB] FAIL gaps_count: got %0d, expected 8", cnt); else n_pass++;
    n_checks++; if (lat !== last_acc + 1) $display("[TB] FAIL gaps_latency: got %0d, expected %0d", lat, last_acc + 1); else n_pass++;
    release_result();
  endtask

  task automatic test_done_stall();
    logic       ns;
    logic [3:0] cnt;
    int lat, last_acc;
    bit to;
    do_eval(1'b0, 1'b0, 9'h000, 9'h000, 8'b01000110, 0, ns, cnt, lat, last_acc, to);
    n_checks++; if (to) $display("[TB] FAIL stall_timeout: got no out_valid, expected one"); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      cur_state = 1'b1;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_out_valid: cycle %0d got %0b, expected 1", i, out_valid); else n_pass++;
      n_checks++; if (next_state !== 1'b1) $display("[TB] FAIL stall_next_state: cycle %0d got %0b, expected 1", i, next_state); else n_pass++;
      n_checks++; if (count !== 4'd3) $display("[TB] FAIL stall_count: cycle %0d got %0d, expected 3", i, count); else n_pass++;
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL handshake_out_valid: got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL handshake_busy: got %0b, expected 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL start_during_handshake: busy got %0b, expected 0", busy); else n_pass++;
    n_checks++; if (next_state !== 1'b1) $display("[TB] FAIL idle_hold_next_state: got %0b, expected 1", next_state); else n_pass++;
    n_checks++; if (count !== 4'd3) $display("[TB] FAIL idle_hold_count: got %0d, expected 3", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic       ns;
    logic [3:0] cnt;
    int lat, last_acc;
    bit to;
    @(negedge clk);
    start = 1'b1;
    cur_state = 1'b1;
    use_custom = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nb_valid = 1'b1;
      nb_bit = 1'b1;
      @(negedge clk);
    end
    nb_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %0b, expected 0", busy); else n_pass++;
    n_checks++; if (nb_ready !== 1'b0) $display("[TB] FAIL midreset_nb_ready: got %0b, expected 0", nb_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midreset_out_valid: got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (next_state !== 1'b0) $display("[TB] FAIL midreset_next_state: got %0b, expected 0", next_state); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("[TB] FAIL midreset_count: got %0d, expected 0", count); else n_pass++;
    do_eval(1'b0, 1'b0, 9'h000, 9'h000, 8'b00000111, 0, ns, cnt, lat, last_acc, to);
    n_checks++; if (to) $display("[TB] FAIL after_reset_timeout: got no out_valid, expected one"); else n_pass++;
    n_checks++; if (ns !== 1'b1) $display("[TB] FAIL after_reset_next_state: got %0b, expected 1", ns); else n_pass++;
    n_checks++; if (cnt !== 4'd3) $display("[TB] FAIL after_reset_count: got %0d, expected 3", cnt); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL done_reset_out_valid: got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (next_state !== 1'b0) $display("[TB] FAIL done_reset_next_state: got %0b, expected 0", next_state); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("[TB] FAIL done_reset_count: got %0d, expected 0", count); else n_pass++;
  endtask

  task automatic test_random();
    logic       ns, cur, uc, exp_ns;
    logic [8:0] bm, sm;
    logic [7:0] bits;
    logic [3:0] cnt;
    int lat, last_acc;
    bit to;
    for (int i = 0; i < 25; i++) begin
      cur  = 1'($urandom_range(0, 1));
      uc   = 1'($urandom_range(0, 1));
      bm   = 9'($urandom);
      sm   = 9'($urandom);
      bits = 8'($urandom);
      exp_ns = ref_next(cur, uc, bm, sm, bits);
      do_eval(cur, uc, bm, sm, bits, 2, ns, cnt, lat, last_acc, to);
      n_checks++; if (to) $display("[TB] FAIL random_timeout: iter %0d got no out_valid, expected one", i); else n_pass++;
      n_checks++; if (ns !== exp_ns) $display("[TB] FAIL random_next_state: iter %0d got %0b, expected %0b", i, ns, exp_ns); else n_pass++;
      n_checks++; if (cnt !== 4'($countones(bits))) $display("[TB] FAIL random_count: iter %0d got %0d, expected %0d", i, cnt, $countones(bits)); else n_pass++;
      n_checks++; if (!to && lat !== last_acc + 1) $display("[TB] FAIL random_latency: iter %0d got %0d, expected %0d", i, lat, last_acc + 1); else n_pass++;
      release_result();
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    cur_state = 1'b0;
    use_custom = 1'b0;
    birth_mask = '0;
    survive_mask = '0;
    nb_valid = 1'b0;
    nb_bit = 1'b0;
    out_ready = 1'b0;
    $display("[TB] life_rule_engine bench starting");
    test_reset();
    test_default_rule();
    test_highlife();
    test_gaps();
    test_done_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/life_rule_engine.md
Name: life_rule_engine

Overview:
- Sequential successor to the naive 2-or-3 neighbour comparator in the life circuit.
- Accepts one cell's current state, then its neighbour bits serially over a valid/ready stream, and counts them.
- Evaluates a configurable birth/survive rule and presents the cell's next state on an output valid/ready handshake.
- Sits between the grid neighbour-scan sequencer and the grid state writeback.

Parameters:
- N_NEIGHBORS, 8: neighbour bits per evaluation (range 1..15).
- COUNT_W, $clog2(N_NEIGHBORS+1): width of the neighbour count.
- BIRTH_DEFAULT, 9'b000001000: bit k=1 means a dead cell with k live neighbours is born (B3). Width N_NEIGHBORS+1.
- SURVIVE_DEFAULT, 9'b000001100: bit k=1 means a live cell with k live neighbours survives (S23). Width N_NEIGHBORS+1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin evaluation; honoured only in IDLE.
- cur_state  in  1  current cell state; sampled with start.
- use_custom  in  1  select birth_mask/survive_mask instead of the defaults; sampled with start.
- birth_mask  in  N_NEIGHBORS+1  runtime birth rule; sampled with start.
- survive_mask  in  N_NEIGHBORS+1  runtime survive rule; sampled with start.
- nb_valid  in  1  neighbour bit valid.
- nb_bit  in  1  neighbour alive flag.
- nb_ready  out  1  engine accepts a neighbour bit this cycle.
- busy  out  1  high in any state except IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- next_state  out  1  evaluated next cell state.
- count  out  COUNT_W  live neighbour total for the presented result.

Behaviour:
- FSM states: IDLE, ACCUM, DONE.
- Reset (rst=0 at a clock edge, from any state, including mid-ACCUM or mid-DONE):
  - state goes to IDLE.
  - nb_ready=0, busy=0, out_valid=0, next_state=0, count=0.
  - Internal beat index and latched masks are cleared; no partial result survives.
- IDLE:
  - nb_ready=0, out_valid=0.
  - On start=1: latch cur_state; latch the rule masks (custom if use_custom=1, else the defaults).
  - Clear the accumulator and beat index; go to ACCUM next cycle.
- ACCUM:
  - nb_ready=1, combinational from state only.
  - A beat is accepted on nb_valid & nb_ready; on acceptance, accumulator += nb_bit and index += 1.
  - Cycles with nb_valid=0 change nothing; gaps of any length are allowed.
  - On the N_NEIGHBORS-th accepted beat, compute total = accumulator + nb_bit (at most N_NEIGHBORS, no overflow).
  - Register next_state = cur_latched ? survive[total] : birth[total], and register count = total.
  - Go to DONE; out_valid=1 in the cycle after the last beat.
  - Latency from start to out_valid = N_NEIGHBORS+1 cycles minimum, with nb_valid held high.
- DONE:
  - nb_ready=0, out_valid=1.
  - next_state and count stay stable until the handshake completes.
  - On out_valid & out_ready, go to IDLE next cycle; out_valid drops that cycle.
  - next_state and count hold their last values in IDLE until the next result is registered.
- start outside IDLE is ignored, including the cycle the DONE handshake completes.
  - No back-to-back bypass: a new start is honoured no earlier than the first IDLE cycle.
- Sampled cur_state and masks are held for the whole evaluation; input changes after start have no effect.
- Mask bits above N_NEIGHBORS do not exist; the mask index is always within range.

Test Plan:
- Default rule (use_custom=0), cur_state=1, neighbour bits 1,1,0,0,0,0,0,0 with nb_valid held high -> out_valid at cycle 9 after start, next_state=1, count=2.
- Default rule, cur_state=0, 3 live neighbours -> next_state=1, count=3. Then cur_state=0 with 2 live -> next_state=0. Then cur_state=1 with 4 live -> next_state=0.
- use_custom=1, birth_mask=9'b001001000, survive_mask=9'b000001100 (HighLife), cur_state=0, 6 live neighbours -> next_state=1, count=6.
  - Masks changed to all zeros one cycle after start -> result unchanged.
- nb_valid toggling 1,0,0,1,... with 8 live beats total, cur_state=1:
  - count advances only on accepted beats.
  - Result is next_state=0, count=8.
  - out_valid is asserted exactly one cycle after the 8th accepted beat.
- out_ready held low 5 cycles in DONE -> out_valid, next_state and count stable for all 5 cycles.
  - start pulsed during DONE is ignored.
  - out_ready=1 -> IDLE next cycle, busy=0.
- rst=0 after 4 accepted beats -> next cycle IDLE, all outputs 0.
  - New start with 3 live neighbours, cur_state=0 -> next_state=1, count=3; no carry-over from the aborted evaluation.
